spar_instr_sequencer: RTL and testbench

//  Upstream issue stage for the bit-serial PE-array controller. Holds a small program in instruction memory,

---
 rtl/spar_isa_pkg.sv | 38 +++
 rtl/spar_imem.sv | 22 ++
 rtl/spar_instr_sequencer.sv | 127 ++++++++++++
 tb/tb_spar_instr_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spar_isa_pkg.sv
// rtl/spar_isa_pkg.sv - opcode map, per-opcode cycle budgets and sequencer states
package spar_isa_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_MUL   = 6'd2;
  localparam logic [5:0] OP_EAST  = 6'd5;
  localparam logic [5:0] OP_WEST  = 6'd6;
  localparam logic [5:0] OP_SOUTH = 6'd7;
  localparam logic [5:0] OP_NORTH = 6'd8;
  localparam logic [5:0] OP_RADD  = 6'd9;
  localparam logic [5:0] OP_RSUB  = 6'd10;
  localparam logic [5:0] OP_COPY  = 6'd11;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_EXEC,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Cycles the controller needs after its start cycle; 0 marks HALT or an undefined opcode.
  function automatic logic [31:0] budget(input logic [5:0] opcode, input int length,
                                         input int mul_budget);
    case (opcode)
      OP_ADD, OP_SUB, OP_RADD, OP_RSUB: return 32'(2 * length + 1);
      OP_EAST, OP_NORTH:                return 32'(length + 2);
      OP_WEST, OP_SOUTH, OP_COPY:       return 32'(length + 1);
      OP_MUL:                           return 32'(mul_budget);
      default:                          return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/spar_imem.sv
// rtl/spar_imem.sv - simple dual-port instruction RAM, host write port, registered read port
module spar_imem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  // No reset on the array: program contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spar_instr_sequencer.sv
// rtl/spar_instr_sequencer.sv - fetches, issues and times instructions for the bit-serial PE-array controller
module spar_instr_sequencer
  import spar_isa_pkg::*;
#(
  parameter int LENGTH     = 32,
  parameter int ADDR_W     = 8,
  parameter int MUL_BUDGET = (LENGTH + 1) * (2 * LENGTH + 6)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              run,
  input  logic              abort,
  output logic [31:0]       instruction,
  output logic              ctrl_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal
);

  localparam int TW = $clog2(MUL_BUDGET + 1);
  localparam logic [ADDR_W-1:0] LAST_PC = '1;

  state_t        state;
  logic [TW-1:0] timer;
  logic          start_q;
  logic [31:0]   rd_data;
  logic [5:0]    fetched_op;
  logic          fetched_legal;
  logic [31:0]   issue_budget;

  assign fetched_op    = rd_data[31:26];
  assign fetched_legal = budget(fetched_op, LENGTH, MUL_BUDGET) != 32'd0;
  assign issue_budget  = budget(instruction[31:26], LENGTH, MUL_BUDGET);

  // An abort in the ISSUE cycle must cancel the pulse that is already on the wire.
  assign ctrl_start = start_q && !abort;

  spar_imem #(.ADDR_W(ADDR_W)) u_imem (
    .clk     (clk),
    .we      (load_we && !busy),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (state == ST_FETCH),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      instruction <= '0;
      start_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pc          <= '0;
      illegal     <= 1'b0;
      timer       <= '0;
    end else if (abort) begin
      start_q <= 1'b0;
      timer   <= '0;
      if (state == ST_IDLE || state == ST_DONE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        state <= ST_DONE;
        busy  <= 1'b1;
        done  <= 1'b1;
      end
    end else begin
      done    <= 1'b0;
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            pc      <= '0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          if (fetched_op == OP_HALT) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (!fetched_legal) begin
            instruction <= rd_data;
            illegal     <= 1'b1;
            state       <= ST_NEXT;
          end else begin
            instruction <= rd_data;
            start_q     <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= TW'(issue_budget - 32'd1);
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (timer == '0) state <= ST_NEXT;
          else timer <= timer - TW'(1);
        end
        ST_NEXT: begin
          if (pc == LAST_PC) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            pc    <= pc + ADDR_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spar_instr_sequencer.sv
// tb/tb_spar_instr_sequencer.sv - scoreboard bench for the instruction sequencer (LENGTH=4, ADDR_W=4)
module tb_spar_instr_sequencer;

  localparam int LENGTH = 4;
  localparam int ADDR_W = 4;

  localparam logic [31:0] I_ADD  = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] I_EAST = {6'd5, 26'd7};
  localparam logic [31:0] I_WEST = {6'd6, 26'd9};
  localparam logic [31:0] I_MUL  = {6'd2, 26'd3};
  localparam logic [31:0] I_ILL  = {6'd4, 26'd1};
  localparam logic [31:0] I_COPY = {6'd11, 26'd0};
  localparam logic [31:0] I_HALT = {6'd63, 26'd0};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [31:0]       load_data = '0;
  logic              run = 1'b0;
  logic              abort = 1'b0;
  logic [31:0]       instruction;
  logic              ctrl_start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic              illegal;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit                is_done;
    int                at;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    bit                ill;
  } ev_t;
  ev_t exp_q[$];

  spar_instr_sequencer #(.LENGTH(LENGTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .run         (run),
    .abort       (abort),
    .instruction (instruction),
    .ctrl_start  (ctrl_start),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void exp_start(input int at, input logic [31:0] ins, input logic [ADDR_W-1:0] p);
    ev_t e;
    e.is_done = 1'b0; e.at = at; e.instr = ins; e.pc = p; e.ill = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_done(input int at, input logic [ADDR_W-1:0] p, input bit ill);
    ev_t e;
    e.is_done = 1'b1; e.at = at; e.instr = '0; e.pc = p; e.ill = ill;
    exp_q.push_back(e);
  endfunction

  // Monitor: every start or done pulse consumes the oldest expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (ctrl_start || done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got start=%0b done=%0b pc=%0d at cycle %0d, expected none",
                 ctrl_start, done, pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_done", 32'(done), 32'(e.is_done));
        check("event_cycle", 32'(cyc), 32'(e.at));
        check("event_pc", 32'(pc), 32'(e.pc));
        if (e.is_done) check("done_illegal", 32'(illegal), 32'(e.ill));
        else check("start_instruction", instruction, e.instr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin
      tick(1);
      k++;
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick(1);
    load_we = 1'b0;
  endtask

  task automatic do_run(output int r);
    r = cyc;
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instruction"}, instruction, 32'd0);
    check({tag, "_ctrl_start"}, 32'(ctrl_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int r;
    int r2;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(2);

    // ADD then HALT: start 3 cycles after run, 9-cycle EXEC, done with pc=1.
    load(4'd0, I_ADD);
    load(4'd1, I_HALT);
    do_run(r);
    exp_start(r + 3, I_ADD, 4'd0);
    exp_done(r + 16, 4'd1, 1'b0);
    wait_until(r + 4);
    check("t1_instr_exec_first", instruction, I_ADD);
    wait_until(r + 13);
    check("t1_instr_next", instruction, I_ADD);
    wait_until(r + 16);
    check("t1_busy_at_done", 32'(busy), 32'd1);
    wait_until(r + 17);
    check("t1_busy_after_done", 32'(busy), 32'd0);
    check("t1_pc_final", 32'(pc), 32'd1);

    // EAST (6) then WEST (5): starts 10 apart, done 9 after the second.
    load(4'd0, I_EAST);
    load(4'd1, I_WEST);
    load(4'd2, I_HALT);
    do_run(r);
    exp_start(r + 3, I_EAST, 4'd0);
    exp_start(r + 13, I_WEST, 4'd1);
    exp_done(r + 22, 4'd2, 1'b0);
    wait_until(r + 23);
    check("t2_idle", 32'(busy), 32'd0);

    // Undefined opcode is skipped without a start; flag is sticky.
    load(4'd0, I_ILL);
    load(4'd1, I_ADD);
    load(4'd2, I_HALT);
    do_run(r);
    exp_start(r + 6, I_ADD, 4'd1);
    exp_done(r + 19, 4'd2, 1'b1);
    wait_until(r + 4);
    check("t3_illegal_set", 32'(illegal), 32'd1);
    wait_until(r + 20);
    check("t3_illegal_sticky", 32'(illegal), 32'd1);

    // MUL aborted at EXEC cycle 10, then rerun to completion (70-cycle budget).
    load(4'd0, I_MUL);
    load(4'd1, I_HALT);
    do_run(r);
    exp_start(r + 3, I_MUL, 4'd0);
    wait_until(r + 13);
    abort = 1'b1;
    exp_done(r + 14, 4'd0, 1'b0);
    tick(1);
    abort = 1'b0;
    wait_until(r + 15);
    check("t4_idle_after_abort", 32'(busy), 32'd0);
    check("t4_start_low_after_abort", 32'(ctrl_start), 32'd0);
    do_run(r2);
    exp_start(r2 + 3, I_MUL, 4'd0);
    exp_done(r2 + 77, 4'd1, 1'b0);
    wait_until(r2 + 78);
    check("t4_rerun_idle", 32'(busy), 32'd0);

    // run together with abort in IDLE: nothing happens.
    run = 1'b1;
    abort = 1'b1;
    tick(1);
    run = 1'b0;
    abort = 1'b0;
    tick(1);
    check("t4_run_abort_idle", 32'(busy), 32'd0);

    // Sixteen COPYs and no HALT: end after the last address, no wrap.
    for (int k = 0; k < 16; k++) load(4'(k), I_COPY | 32'(k));
    do_run(r);
    for (int k = 0; k < 16; k++) exp_start(r + 3 + 9 * k, I_COPY | 32'(k), 4'(k));
    exp_done(r + 145, 4'd15, 1'b0);
    wait_until(r + 146);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_pc_no_wrap", 32'(pc), 32'd15);

    // Reset during EXEC clears every output on the next edge.
    load(4'd0, I_ADD);
    load(4'd1, I_HALT);
    do_run(r);
    exp_start(r + 3, I_ADD, 4'd0);
    wait_until(r + 6);
    reset = 1'b0;
    tick(1);
    check_reset_outputs("t6_midreset");
    reset = 1'b1;
    tick(1);

    // A write while busy is dropped: the next run still sees ADD.
    do_run(r);
    exp_start(r + 3, I_ADD, 4'd0);
    exp_done(r + 16, 4'd1, 1'b0);
    wait_until(r + 5);
    load(4'd0, I_COPY);
    wait_until(r + 17);
    do_run(r);
    exp_start(r + 3, I_ADD, 4'd0);
    exp_done(r + 16, 4'd1, 1'b0);
    wait_until(r + 17);

    // Write and run in the same IDLE cycle: FETCH sees the new word.
    r = cyc;
    load_we = 1'b1; load_addr = 4'd0; load_data = I_WEST; run = 1'b1;
    tick(1);
    load_we = 1'b0; run = 1'b0;
    exp_start(r + 3, I_WEST, 4'd0);
    exp_done(r + 12, 4'd1, 1'b0);
    wait_until(r + 16);

    check("all_events_seen", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
